// File: rtl/rv_pipe_pkg.sv
// Shared constants for the RV pipeline front end.
package rv_pipe_pkg;

  localparam int          DEFAULT_XLEN     = 32;
  localparam int          INSTR_W          = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/param_sync_fifo.sv
// Synchronous FIFO with registered storage; the head entry is read straight
// from the storage array so it is stable while the FIFO is not popped.
module param_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    if (int'(p) == DEPTH - 1) return '0;
    return p + AW'(1);
  endfunction

  // Overflowing pushes and underflowing pops are ignored; a push into a
  // full FIFO is accepted when the head leaves in the same cycle.
  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((int'(cnt) != DEPTH) || do_pop);

  // Control state: pointers and entry count.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write; data is not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (int'(cnt) == DEPTH);

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: issues in-order requests to a variable
// latency instruction memory, queues returned words with their PC for
// decode, and flushes on execute-stage redirects.
module fetch_prefetch_queue
  import rv_pipe_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       imem_req_valid,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_req_ready,
  input  logic                       imem_rsp_valid,
  input  logic [INSTR_W-1:0]         imem_rsp_data,
  input  logic                       dec_ready,
  output logic                       dec_valid,
  output logic [INSTR_W-1:0]         dec_instr,
  output logic [XLEN-1:0]            dec_pc,
  output logic [XLEN-1:0]            dec_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int PW = $clog2(MAX_OUT + 1);

  logic [XLEN-1:0]         fetch_pc;
  logic [OW-1:0]           outstanding;
  logic [OW-1:0]           drop_cnt;
  logic                    flush;
  logic                    space_ok;
  logic                    fire;
  logic                    rsp_keep;
  logic                    deq;

  logic [XLEN-1:0]         pend_pc;
  logic                    pend_full;
  logic                    pend_empty;
  logic [PW-1:0]           pend_count;

  logic [INSTR_W+XLEN-1:0] iq_head;
  logic                    iq_full;
  logic                    iq_empty;
  logic [CW-1:0]           iq_count;
  logic                    unused_flags;

  assign flush    = rst || redirect_valid;
  // Reserving queue space for every outstanding request means a returning
  // word always has a slot.
  assign space_ok = (int'(iq_count) + int'(outstanding) < DEPTH) &&
                    (int'(outstanding) < MAX_OUT);
  assign imem_req_valid = !rst && !redirect_valid && space_ok;
  assign imem_req_addr  = fetch_pc;
  assign fire     = imem_req_valid && imem_req_ready;
  assign rsp_keep = imem_rsp_valid && (drop_cnt == '0) && !flush;
  assign deq      = !iq_empty && dec_ready && !flush;

  param_sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUT)) u_pend_fifo (
    .clk   (clk),
    .clear (flush),
    .push  (fire),
    .din   (fetch_pc),
    .pop   (rsp_keep),
    .dout  (pend_pc),
    .full  (pend_full),
    .empty (pend_empty),
    .count (pend_count)
  );

  param_sync_fifo #(.WIDTH(INSTR_W + XLEN), .DEPTH(DEPTH)) u_instr_queue (
    .clk   (clk),
    .clear (flush),
    .push  (rsp_keep),
    .din   ({imem_rsp_data, pend_pc}),
    .pop   (deq),
    .dout  (iq_head),
    .full  (iq_full),
    .empty (iq_empty),
    .count (iq_count)
  );

  assign unused_flags = ^{pend_full, pend_empty, pend_count, iq_full};

  // Fetch PC: reset, word-aligned redirect target, or advance on fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
    end else if (fire) begin
      fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  // Outstanding and stale-response counters. Outstanding already includes
  // responses owed to earlier redirects, so on a redirect every response not
  // returning this cycle becomes stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + OW'(fire) - OW'(imem_rsp_valid);
      if (redirect_valid) begin
        drop_cnt <= outstanding - OW'(imem_rsp_valid);
      end else if (imem_rsp_valid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

  assign dec_valid    = !iq_empty && !rst;
  assign dec_instr    = dec_valid ? iq_head[XLEN +: INSTR_W] : NOP_INSTR;
  assign dec_pc       = dec_valid ? iq_head[XLEN-1:0] : '0;
  assign dec_pc_plus4 = dec_pc + XLEN'(4);
  assign occupancy    = rst ? '0 : iq_count;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with a behavioural in-order
// instruction memory of configurable response latency.
module tb_fetch_prefetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus4;
  logic [2:0]  occupancy;

  fetch_prefetch_queue #(.XLEN(32), .DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_ready      (dec_ready),
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_pc_plus4   (dec_pc_plus4),
    .occupancy      (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  typedef struct {
    logic        rdy;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [2:0]  e_occ;
    logic        e_req;
  } vec_t;

  req_t        pendq[$];
  logic [31:0] deliv[$];
  int          cyc;
  int          lat;
  int          total;
  int          bad;
  vec_t        t1[7];
  vec_t        t2[15];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0003;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: record handshakes, advance memory model, drive responses.
  task automatic step();
    logic        f;
    logic        r;
    logic [31:0] a;
    f = imem_req_valid && imem_req_ready;
    r = rst;
    a = imem_req_addr;
    if (dec_valid && dec_ready && !redirect_valid && !rst) deliv.push_back(dec_pc);
    @(posedge clk);
    #1;
    cyc++;
    if (r) pendq.delete();
    else if (f) pendq.push_back('{a, cyc - 1 + lat});
    if (!r && pendq.size() > 0 && pendq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(pendq[0].addr);
      void'(pendq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    #1;
  endtask

  task automatic do_reset(input int l);
    lat            = l;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    step();
    step();
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("rst_dec_instr", dec_instr, NOP);
    chk("rst_dec_pc", dec_pc, 32'h0);
    chk("rst_occupancy", {29'b0, occupancy}, 32'd0);
    deliv.delete();
    cyc = 1;
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    for (int k = 0; k < budget && !dec_valid; k++) step();
    chk(name, {31'b0, dec_valid}, 32'd1);
  endtask

  task automatic check_row(input string tag, input vec_t v);
    logic [31:0] ei;
    ei = v.e_vld ? instr_of(v.e_pc) : NOP;
    chk({tag, "_valid"}, {31'b0, dec_valid}, {31'b0, v.e_vld});
    chk({tag, "_pc"}, dec_pc, v.e_pc);
    chk({tag, "_instr"}, dec_instr, ei);
    chk({tag, "_plus4"}, dec_pc_plus4, v.e_pc + 32'd4);
    chk({tag, "_occ"}, {29'b0, occupancy}, {29'b0, v.e_occ});
    chk({tag, "_req"}, {31'b0, imem_req_valid}, {31'b0, v.e_req});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    lat   = 1;
    rst   = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    dec_ready      = 1'b1;

    // Zero-wait streaming: {dec_ready, valid, pc, occupancy, req_valid}
    t1[0] = '{1'b1, 1'b0, 32'h00, 3'd0, 1'b1};
    t1[1] = '{1'b1, 1'b0, 32'h00, 3'd0, 1'b1};
    t1[2] = '{1'b1, 1'b1, 32'h00, 3'd1, 1'b1};
    t1[3] = '{1'b1, 1'b1, 32'h04, 3'd1, 1'b1};
    t1[4] = '{1'b1, 1'b1, 32'h08, 3'd1, 1'b1};
    t1[5] = '{1'b1, 1'b1, 32'h0C, 3'd1, 1'b1};
    t1[6] = '{1'b1, 1'b1, 32'h10, 3'd1, 1'b1};

    // Decode stalled for 10 cycles, then released.
    t2[0]  = '{1'b0, 1'b0, 32'h00, 3'd0, 1'b1};
    t2[1]  = '{1'b0, 1'b0, 32'h00, 3'd0, 1'b1};
    t2[2]  = '{1'b0, 1'b1, 32'h00, 3'd1, 1'b1};
    t2[3]  = '{1'b0, 1'b1, 32'h00, 3'd2, 1'b1};
    t2[4]  = '{1'b0, 1'b1, 32'h00, 3'd3, 1'b0};
    t2[5]  = '{1'b0, 1'b1, 32'h00, 3'd4, 1'b0};
    t2[6]  = '{1'b0, 1'b1, 32'h00, 3'd4, 1'b0};
    t2[7]  = '{1'b0, 1'b1, 32'h00, 3'd4, 1'b0};
    t2[8]  = '{1'b0, 1'b1, 32'h00, 3'd4, 1'b0};
    t2[9]  = '{1'b0, 1'b1, 32'h00, 3'd4, 1'b0};
    t2[10] = '{1'b1, 1'b1, 32'h00, 3'd4, 1'b0};
    t2[11] = '{1'b1, 1'b1, 32'h04, 3'd3, 1'b1};
    t2[12] = '{1'b1, 1'b1, 32'h08, 3'd2, 1'b1};
    t2[13] = '{1'b1, 1'b1, 32'h0C, 3'd2, 1'b1};
    t2[14] = '{1'b1, 1'b1, 32'h10, 3'd2, 1'b1};

    // Streaming with a single-cycle memory.
    do_reset(1);
    for (int i = 0; i < 7; i++) begin
      dec_ready = t1[i].rdy;
      #1;
      check_row("stream", t1[i]);
      step();
    end

    // Backpressure fills the queue, then drains in order.
    do_reset(1);
    for (int i = 0; i < 15; i++) begin
      dec_ready = t2[i].rdy;
      #1;
      check_row("stall", t2[i]);
      chk("stall_space", {31'b0, (int'(occupancy) + pendq.size() + int'(imem_rsp_valid)) <= 4},
          32'd1);
      step();
    end

    // Redirect with two requests in flight on a 3-cycle memory.
    do_reset(3);
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    #1;
    chk("redir3_no_issue", {31'b0, imem_req_valid}, 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("redir3_occ_after", {29'b0, occupancy}, 32'd0);
    chk("redir3_valid_after", {31'b0, dec_valid}, 32'd0);
    wait_valid("redir3_first_timeout", 20);
    chk("redir3_first_pc", dec_pc, 32'h100);
    chk("redir3_first_instr", dec_instr, instr_of(32'h100));
    step();
    wait_valid("redir3_second_timeout", 20);
    chk("redir3_second_pc", dec_pc, 32'h104);

    // Redirect coinciding with a response and a dequeue.
    do_reset(1);
    step();
    step();
    step();
    chk("redir_same_pre_pc", dec_pc, 32'h4);
    chk("redir_same_pre_rsp", {31'b0, dec_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    #1;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("redir_same_occ", {29'b0, occupancy}, 32'd0);
    wait_valid("redir_same_timeout", 20);
    chk("redir_same_pc", dec_pc, 32'h200);
    chk("redir_same_instr", dec_instr, instr_of(32'h200));
    chk("redir_same_deliv", deliv.size(), 32'd1);

    // Memory not ready for 5 cycles.
    do_reset(1);
    step();
    step();
    step();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stallmem_addr", imem_req_addr, 32'h0C);
      chk("stallmem_valid", {31'b0, imem_req_valid}, 32'd1);
      step();
    end
    imem_req_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("stallmem_count", {31'b0, deliv.size() >= 7}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      if (i < deliv.size()) chk("stallmem_seq", deliv[i], 32'(i * 4));
    end

    // Address wrap at the top of the address space, then mid-stream reset.
    do_reset(1);
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    #1;
    step();
    redirect_valid = 1'b0;
    #1;
    wait_valid("wrap_timeout", 20);
    chk("wrap_pc_hi", dec_pc, 32'hFFFF_FFFC);
    chk("wrap_plus4_hi", dec_pc_plus4, 32'h0);
    chk("wrap_instr_hi", dec_instr, instr_of(32'hFFFF_FFFC));
    step();
    chk("wrap_pc_lo", dec_pc, 32'h0);
    chk("wrap_plus4_lo", dec_pc_plus4, 32'h4);
    chk("wrap_valid_lo", {31'b0, dec_valid}, 32'd1);
    rst = 1'b1;
    #1;
    step();
    chk("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("midrst_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("midrst_dec_instr", dec_instr, NOP);
    chk("midrst_dec_pc", dec_pc, 32'h0);
    chk("midrst_occ", {29'b0, occupancy}, 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_resume_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("midrst_resume_addr", imem_req_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
